// File: rtl/keypad_digit_loader_if.sv
// Keypad priority-encoder link: the encoder drives the BCD digit and key-pressed
// flag, and the loader drives the encoder's active-low enable.
interface keypad_digit_loader_if;
  logic [3:0] BCD_in;
  logic       data_valid;
  logic       enable_n;

  modport master (
    output BCD_in,
    output data_valid,
    input  enable_n
  );

  modport slave (
    input  BCD_in,
    input  data_valid,
    output enable_n
  );
endinterface

// File: rtl/keypad_digit_loader.sv
// Debounces keypad encoder presses and shifts each accepted BCD digit into a
// four-digit MM:SS entry register for the timer.
module keypad_digit_loader #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  clear,
  keypad_digit_loader_if.slave  kp,
  output logic [3:0]            min_tens,
  output logic [3:0]            min_ones,
  output logic [3:0]            sec_tens,
  output logic [3:0]            sec_ones,
  output logic [2:0]            digit_count,
  output logic                  full,
  output logic                  digit_strobe,
  output logic                  digit_rejected
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [7:0] N      = 8'(DEBOUNCE_CYCLES);
  localparam bit         SINGLE = (DEBOUNCE_CYCLES == 1);

  logic [1:0] state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] cand_reg, cand_next;
  logic       accept;
  logic [3:0] accept_digit;
  logic       qualifying;
  logic [7:0] cnt_inc;

  assign qualifying = kp.data_valid && load_en && (kp.BCD_in == cand_reg);
  assign cnt_inc    = cnt_reg + 8'd1;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cand_next    = cand_reg;
    accept       = 1'b0;
    accept_digit = cand_reg;
    case (state_reg)
      IDLE: begin
        if (kp.data_valid && load_en) begin
          cand_next    = kp.BCD_in;
          // With N=1 the candidate is not latched yet, so accept straight from the bus.
          accept_digit = kp.BCD_in;
          if (SINGLE) begin
            accept     = 1'b1;
            state_next = HELD;
            cnt_next   = 8'd0;
          end else begin
            cnt_next   = 8'd1;
            state_next = PRESS_WAIT;
          end
        end else begin
          cnt_next = 8'd0;
        end
      end
      PRESS_WAIT: begin
        if (!qualifying) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else if (cnt_inc >= N) begin
          accept     = 1'b1;
          state_next = HELD;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      HELD: begin
        if (!kp.data_valid) begin
          if (SINGLE) begin
            state_next = IDLE;
            cnt_next   = 8'd0;
          end else begin
            state_next = RELEASE_WAIT;
            cnt_next   = 8'd1;
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high returns to HELD without a second acceptance.
        if (kp.data_valid) begin
          state_next = HELD;
          cnt_next   = 8'd0;
        end else if (cnt_inc >= N) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      cand_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kp.enable_n    <= 1'b1;
      min_tens       <= 4'd0;
      min_ones       <= 4'd0;
      sec_tens       <= 4'd0;
      sec_ones       <= 4'd0;
      digit_count    <= 3'd0;
      digit_strobe   <= 1'b0;
      digit_rejected <= 1'b0;
    end else begin
      kp.enable_n    <= ~load_en;
      digit_strobe   <= 1'b0;
      digit_rejected <= 1'b0;
      // Clear beats a coincident acceptance: the digit is dropped silently.
      if (clear) begin
        min_tens    <= 4'd0;
        min_ones    <= 4'd0;
        sec_tens    <= 4'd0;
        sec_ones    <= 4'd0;
        digit_count <= 3'd0;
      end else if (accept) begin
        if ((accept_digit <= 4'd9) && (digit_count != 3'd4)) begin
          min_tens     <= min_ones;
          min_ones     <= sec_tens;
          sec_tens     <= sec_ones;
          sec_ones     <= accept_digit;
          digit_count  <= digit_count + 3'd1;
          digit_strobe <= 1'b1;
        end else begin
          digit_rejected <= 1'b1;
        end
      end
    end
  end

  assign full = (digit_count == 3'd4);

endmodule

// File: tb/tb_keypad_digit_loader.sv
// Cycle-by-cycle vector table for the default N=4 loader, plus a short
// hand-written sequence for an N=1 instance.
module tb_keypad_digit_loader;

  typedef struct {
    logic        rst;
    logic        le;
    logic        clr;
    logic [3:0]  bcd;
    logic        dv;
    logic        stb;
    logic        rej;
    logic [2:0]  cnt;
    logic [15:0] dig;
    logic        enn;
  } vec_t;

  localparam int NONE = 0;
  localparam int STB  = 1;
  localparam int REJ  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic       rst, load_en, clear;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] digit_count;
  logic       full, digit_strobe, digit_rejected;
  keypad_digit_loader_if kp ();

  keypad_digit_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .clear(clear), .kp(kp),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .digit_count(digit_count), .full(full),
    .digit_strobe(digit_strobe), .digit_rejected(digit_rejected)
  );

  // N=1 instance
  logic       rst1, load_en1, clear1;
  logic [3:0] mt1, mo1, st1, so1;
  logic [2:0] cnt1;
  logic       full1, stb1, rej1;
  keypad_digit_loader_if kp1 ();

  keypad_digit_loader #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst1), .load_en(load_en1), .clear(clear1), .kp(kp1),
    .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
    .digit_count(cnt1), .full(full1),
    .digit_strobe(stb1), .digit_rejected(rej1)
  );

  vec_t        vecs[$];
  logic [2:0]  cur_cnt;
  logic [15:0] cur_dig;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic add(input logic r, input logic le, input logic cl, input logic [3:0] b,
                     input logic dv, input logic stb, input logic rej,
                     input logic [2:0] cnt, input logic [15:0] dig, input logic enn);
    vec_t v;
    v.rst = r; v.le = le; v.clr = cl; v.bcd = b; v.dv = dv;
    v.stb = stb; v.rej = rej; v.cnt = cnt; v.dig = dig; v.enn = enn;
    vecs.push_back(v);
  endtask

  // n quiet cycles: outputs hold at the current expected value
  task automatic hold(input int n, input logic le, input logic dv, input logic [3:0] b);
    for (int i = 0; i < n; i++) add(1'b0, le, 1'b0, b, dv, 1'b0, 1'b0, cur_cnt, cur_dig, ~le);
  endtask

  task automatic accept(input logic [3:0] b, input int kind, input logic [2:0] cnt,
                        input logic [15:0] dig);
    cur_cnt = cnt;
    cur_dig = dig;
    add(1'b0, 1'b1, 1'b0, b, 1'b1, kind == STB, kind == REJ, cnt, dig, 1'b0);
  endtask

  task automatic press(input logic [3:0] b, input int kind, input logic [2:0] cnt,
                       input logic [15:0] dig);
    hold(3, 1'b1, 1'b1, b);
    accept(b, kind, cnt, dig);
    hold(4, 1'b1, 1'b0, b);
  endtask

  task automatic clear_row();
    cur_cnt = 3'd0;
    cur_dig = 16'h0000;
    add(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
  endtask

  task automatic step1(input logic dv, input logic [3:0] b, input logic stb,
                       input logic rej, input logic [2:0] cnt, input logic [15:0] dig);
    @(negedge clk);
    kp1.data_valid = dv;
    kp1.BCD_in     = b;
    @(posedge clk);
    #1;
    check("n1_strobe", int'(stb1), int'(stb));
    check("n1_reject", int'(rej1), int'(rej));
    check("n1_count",  int'(cnt1), int'(cnt));
    check("n1_digits", int'({mt1, mo1, st1, so1}), int'(dig));
    $display("n1 dv=%b bcd=%h -> cnt=%0d dig=%h stb=%b rej=%b", dv, b, cnt1,
             {mt1, mo1, st1, so1}, stb1, rej1);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; clear = 1'b0;
    kp.BCD_in = 4'd0; kp.data_valid = 1'b0;
    rst1 = 1'b1; load_en1 = 1'b0; clear1 = 1'b0;
    kp1.BCD_in = 4'd0; kp1.data_valid = 1'b0;
    cur_cnt = 3'd0; cur_dig = 16'h0000;

    // reset
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
    // 7 held six cycles, released five: one strobe on 4th valid edge
    hold(3, 1'b1, 1'b1, 4'd7);
    accept(4'd7, STB, 3'd1, 16'h0007);
    hold(2, 1'b1, 1'b1, 4'd7);
    hold(5, 1'b1, 1'b0, 4'd7);
    // bounce: 3 high, 1 low, 3 high -> nothing
    hold(3, 1'b1, 1'b1, 4'd5);
    hold(1, 1'b1, 1'b0, 4'd5);
    hold(3, 1'b1, 1'b1, 4'd5);
    hold(1, 1'b1, 1'b0, 4'd5);
    // load_en low blocks entry and raises enable_n
    hold(4, 1'b0, 1'b1, 4'd5);
    hold(1, 1'b1, 1'b0, 4'd5);
    // 12:30 then a rejected fifth digit
    clear_row();
    press(4'd1, STB, 3'd1, 16'h0001);
    press(4'd2, STB, 3'd2, 16'h0012);
    press(4'd3, STB, 3'd3, 16'h0123);
    press(4'd0, STB, 3'd4, 16'h1230);
    press(4'd9, REJ, 3'd4, 16'h1230);
    // BCD changes 3->4 on 2nd edge: debounce restarts
    clear_row();
    hold(1, 1'b1, 1'b1, 4'd3);
    hold(1, 1'b1, 1'b1, 4'd4);
    hold(3, 1'b1, 1'b1, 4'd4);
    accept(4'd4, STB, 3'd1, 16'h0004);
    hold(1, 1'b1, 1'b1, 4'd4);
    hold(4, 1'b1, 1'b0, 4'd4);
    // non-BCD code rejected while not full
    press(4'hB, REJ, 3'd1, 16'h0004);
    // release bounce inside a hold: no second acceptance
    hold(3, 1'b1, 1'b1, 4'd6);
    accept(4'd6, STB, 3'd2, 16'h0046);
    hold(3, 1'b1, 1'b1, 4'd6);
    hold(2, 1'b1, 1'b0, 4'd6);
    hold(3, 1'b1, 1'b1, 4'd6);
    hold(4, 1'b1, 1'b0, 4'd6);
    // clear coincident with acceptance: clear wins, no pulses
    hold(3, 1'b1, 1'b1, 4'd8);
    cur_cnt = 3'd0; cur_dig = 16'h0000;
    add(1'b0, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    hold(1, 1'b1, 1'b1, 4'd8);
    hold(4, 1'b1, 1'b0, 4'd8);
    // reset during HELD, key still down: re-accepted as a new press
    hold(3, 1'b1, 1'b1, 4'd2);
    accept(4'd2, STB, 3'd1, 16'h0002);
    hold(1, 1'b1, 1'b1, 4'd2);
    cur_cnt = 3'd0; cur_dig = 16'h0000;
    add(1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
    hold(3, 1'b1, 1'b1, 4'd2);
    accept(4'd2, STB, 3'd1, 16'h0002);
    hold(4, 1'b1, 1'b0, 4'd2);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      load_en       = vecs[i].le;
      clear         = vecs[i].clr;
      kp.BCD_in     = vecs[i].bcd;
      kp.data_valid = vecs[i].dv;
      if (i == 1) rst1 = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_strobe", i), int'(digit_strobe), int'(vecs[i].stb));
      check($sformatf("v%0d_reject", i), int'(digit_rejected), int'(vecs[i].rej));
      check($sformatf("v%0d_count", i), int'(digit_count), int'(vecs[i].cnt));
      check($sformatf("v%0d_digits", i), int'({min_tens, min_ones, sec_tens, sec_ones}),
            int'(vecs[i].dig));
      check($sformatf("v%0d_full", i), int'(full), int'(vecs[i].cnt == 3'd4));
      check($sformatf("v%0d_enable_n", i), int'(kp.enable_n), int'(vecs[i].enn));
      $display("vec %0d rst=%b le=%b clr=%b bcd=%h dv=%b -> cnt=%0d dig=%h stb=%b rej=%b en_n=%b",
               i, vecs[i].rst, vecs[i].le, vecs[i].clr, vecs[i].bcd, vecs[i].dv, digit_count,
               {min_tens, min_ones, sec_tens, sec_ones}, digit_strobe, digit_rejected,
               kp.enable_n);
    end

    // N=1: accept on first edge, next press two edges later
    @(negedge clk);
    load_en1 = 1'b1;
    step1(1'b1, 4'd3, 1'b1, 1'b0, 3'd1, 16'h0003);
    step1(1'b1, 4'd3, 1'b0, 1'b0, 3'd1, 16'h0003);
    step1(1'b0, 4'd3, 1'b0, 1'b0, 3'd1, 16'h0003);
    step1(1'b1, 4'd4, 1'b1, 1'b0, 3'd2, 16'h0034);
    step1(1'b0, 4'd4, 1'b0, 1'b0, 3'd2, 16'h0034);
    step1(1'b1, 4'hA, 1'b0, 1'b1, 3'd2, 16'h0034);
    check("n1_enable_n", int'(kp1.enable_n), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
